// File: rtl/fraction_reducer_pkg.sv
// -----------------------------------------------------------------------------
// fraction_reducer_pkg
// Shared definitions for the fraction reducer slice:
//   FR_W            default operand / GCD / result width
//   ST_*_BIT        bit positions of the one-hot controller states
//   state_t         one-hot (7-bit) controller state encoding
// -----------------------------------------------------------------------------
package fraction_reducer_pkg;

   localparam int unsigned FR_W = 7;

   localparam int unsigned ST_IDLE_BIT      = 0;
   localparam int unsigned ST_LAUNCH_BIT    = 1;
   localparam int unsigned ST_WAIT_BUSY_BIT = 2;
   localparam int unsigned ST_WAIT_DONE_BIT = 3;
   localparam int unsigned ST_DIV_A_BIT     = 4;
   localparam int unsigned ST_DIV_B_BIT     = 5;
   localparam int unsigned ST_OUT_BIT       = 6;

   typedef enum logic [6:0] {
      ST_IDLE      = 7'b000_0001,
      ST_LAUNCH    = 7'b000_0010,
      ST_WAIT_BUSY = 7'b000_0100,
      ST_WAIT_DONE = 7'b000_1000,
      ST_DIV_A     = 7'b001_0000,
      ST_DIV_B     = 7'b010_0000,
      ST_OUT       = 7'b100_0000
   } state_t;

endpackage

// File: rtl/fraction_reducer_if.sv
// -----------------------------------------------------------------------------
// fraction_reducer_if
// Bundles the operand input port, the GCD engine link and the result port.
//   in_valid/in_ready/a_in/b_in                 operand pair handshake
//   gcd_start/gcd_a/gcd_b/gcd_ready/gcd_r       GCD engine launch and result
//   out_valid/out_ready/num_out/den_out/gcd_out/err   reduced result handshake
// Modports:
//   master  the fraction reducer itself
//   slave   the surrounding system (operand source, GCD engine, consumer)
// -----------------------------------------------------------------------------
interface fraction_reducer_if
   import fraction_reducer_pkg::*;
#(
   parameter int unsigned W = FR_W
);

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;

   logic         gcd_start;
   logic [W-1:0] gcd_a;
   logic [W-1:0] gcd_b;
   logic         gcd_ready;
   logic [W-1:0] gcd_r;

   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] num_out;
   logic [W-1:0] den_out;
   logic [W-1:0] gcd_out;
   logic         err;

   modport master (
      input  in_valid, a_in, b_in, gcd_ready, gcd_r, out_ready,
      output in_ready, gcd_start, gcd_a, gcd_b,
             out_valid, num_out, den_out, gcd_out, err
   );

   modport slave (
      output in_valid, a_in, b_in, gcd_ready, gcd_r, out_ready,
      input  in_ready, gcd_start, gcd_a, gcd_b,
             out_valid, num_out, den_out, gcd_out, err
   );

endinterface

// File: rtl/fraction_reducer_serial_divider.sv
// -----------------------------------------------------------------------------
// fraction_reducer_serial_divider
// Unsigned restoring divider producing one quotient bit per clock.
// The first quotient bit is formed on the same edge that samples start, so
// with start high in cycle 0 the result is complete and done pulses in cycle W.
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      load dividend/divisor and begin (overrides a running division)
//   dividend   W-bit dividend, sampled with start
//   divisor    W-bit divisor, sampled with start; never zero
//   done       one-cycle pulse, quotient/remainder valid in that cycle
//   quotient   W-bit quotient
//   remainder  W-bit remainder
// -----------------------------------------------------------------------------
module fraction_reducer_serial_divider
   import fraction_reducer_pkg::*;
#(
   parameter int unsigned W = FR_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         done,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder
);

   localparam int unsigned   CW       = $clog2(W + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

   logic [W-1:0]  rem_r;
   logic [W-1:0]  quo_r;
   logic [W-1:0]  dsr_r;
   logic [CW-1:0] cnt_r;
   logic          done_r;

   logic [W-1:0]  src_rem_s;
   logic [W-1:0]  src_quo_s;
   logic [W-1:0]  src_dsr_s;
   logic [W-1:0]  step_rem_s;
   logic [W-1:0]  step_quo_s;

   // One restoring step: shift the next dividend bit into the partial
   // remainder, subtract the divisor when it fits and shift in the quotient
   // bit. quo holds the not-yet-consumed dividend bits in its upper part.
   function automatic logic [2*W-1:0] restore_step(
      input logic [W-1:0] rem,
      input logic [W-1:0] quo,
      input logic [W-1:0] dsr
   );
      logic [W:0]   shifted;
      logic [W-1:0] rem_n;
      logic         q_bit;
      shifted = {rem, quo[W-1]};
      if (shifted >= {1'b0, dsr}) begin
         // The true difference is below dsr, so the low W bits are exact.
         rem_n = shifted[W-1:0] - dsr;
         q_bit = 1'b1;
      end else begin
         rem_n = shifted[W-1:0];
         q_bit = 1'b0;
      end
      return {rem_n, quo[W-2:0], q_bit};
   endfunction

   // Select the step source: fresh operands on start, running state otherwise.
   always_comb begin
      src_rem_s = rem_r;
      src_quo_s = quo_r;
      src_dsr_s = dsr_r;
      if (start) begin
         src_rem_s = {W{1'b0}};
         src_quo_s = dividend;
         src_dsr_s = divisor;
      end else begin
         src_rem_s = rem_r;
         src_quo_s = quo_r;
         src_dsr_s = dsr_r;
      end
      {step_rem_s, step_quo_s} = restore_step(src_rem_s, src_quo_s, src_dsr_s);
   end

   // Iteration registers, remaining-step counter and the done pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rem_r  <= {W{1'b0}};
         quo_r  <= {W{1'b0}};
         dsr_r  <= {W{1'b0}};
         cnt_r  <= CNT_ZERO;
         done_r <= 1'b0;
      end else if (start) begin
         rem_r  <= step_rem_s;
         quo_r  <= step_quo_s;
         dsr_r  <= divisor;
         cnt_r  <= CNT_INIT;
         done_r <= (CNT_INIT == CNT_ZERO);
      end else if (cnt_r != CNT_ZERO) begin
         rem_r  <= step_rem_s;
         quo_r  <= step_quo_s;
         cnt_r  <= cnt_r - CNT_ONE;
         done_r <= (cnt_r == CNT_ONE);
      end else begin
         done_r <= 1'b0;
      end
   end

   assign done      = done_r;
   assign quotient  = quo_r;
   assign remainder = rem_r;

endmodule

// File: rtl/fraction_reducer.sv
// -----------------------------------------------------------------------------
// fraction_reducer
// Reduces a/b to lowest terms: launches the external GCD engine, captures its
// result, then divides a and b by it with a shared serial divider.
//   clk     rising-edge clock
//   reset   asynchronous active-low reset (deassertion synchronised inside)
//   bus     fraction_reducer_if.master:
//             in_valid/in_ready/a_in/b_in        operand pair input
//             gcd_start/gcd_a/gcd_b              engine launch, operands held
//             gcd_ready/gcd_r                    engine idle / result
//             out_valid/out_ready                result handshake
//             num_out/den_out/gcd_out/err        reduced fraction, GCD, error
// A 0/0 pair skips the engine and reports err with all-zero data. err is also
// raised if either division leaves a remainder.
// -----------------------------------------------------------------------------
module fraction_reducer
   import fraction_reducer_pkg::*;
#(
   parameter int unsigned W = FR_W
) (
   input  logic              clk,
   input  logic              reset,
   fraction_reducer_if.master bus
);

   logic         rst_sync_r;

   state_t       state_r;
   state_t       state_s;

   logic [W-1:0] a_r;
   logic [W-1:0] b_r;
   logic [W-1:0] gcd_val_r;
   logic [W-1:0] num_r;
   logic [W-1:0] den_r;
   logic         err_r;
   logic         div_kick_r;

   logic         both_zero_s;
   logic         div_start_s;
   logic [W-1:0] div_dividend_s;
   logic         div_done_s;
   logic [W-1:0] div_quo_s;
   logic [W-1:0] div_rem_s;

   // Reset synchroniser: assertion is immediate, release lands on the first
   // clock edge so a pair can be accepted on the second edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_sync_r <= 1'b0;
      end else begin
         rst_sync_r <= 1'b1;
      end
   end

   // Divider control: the first division is kicked one cycle after the GCD
   // capture; the second starts in the very cycle the first one completes.
   always_comb begin
      both_zero_s    = (bus.a_in == {W{1'b0}}) && (bus.b_in == {W{1'b0}});
      div_start_s    = div_kick_r;
      div_dividend_s = a_r;
      if (state_r[ST_DIV_A_BIT] && div_done_s) begin
         div_start_s    = 1'b1;
         div_dividend_s = b_r;
      end else begin
         div_start_s    = div_kick_r;
         div_dividend_s = a_r;
      end
   end

   // Controller next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.in_valid) begin
               if (both_zero_s) begin
                  state_s = ST_OUT;
               end else begin
                  state_s = ST_LAUNCH;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LAUNCH: begin
            // A busy engine cannot take the launch; keep gcd_start asserted.
            if (bus.gcd_ready) begin
               state_s = ST_WAIT_BUSY;
            end else begin
               state_s = ST_LAUNCH;
            end
         end
         ST_WAIT_BUSY: begin
            if (!bus.gcd_ready) begin
               state_s = ST_WAIT_DONE;
            end else begin
               state_s = ST_WAIT_BUSY;
            end
         end
         ST_WAIT_DONE: begin
            if (bus.gcd_ready) begin
               state_s = ST_DIV_A;
            end else begin
               state_s = ST_WAIT_DONE;
            end
         end
         ST_DIV_A: begin
            if (div_done_s) begin
               state_s = ST_DIV_B;
            end else begin
               state_s = ST_DIV_A;
            end
         end
         ST_DIV_B: begin
            if (div_done_s) begin
               state_s = ST_OUT;
            end else begin
               state_s = ST_DIV_B;
            end
         end
         ST_OUT: begin
            if (bus.out_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_OUT;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Controller state register.
   always_ff @(posedge clk or negedge rst_sync_r) begin
      if (!rst_sync_r) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // One-cycle kick for the first division, issued as the GCD is captured.
   always_ff @(posedge clk or negedge rst_sync_r) begin
      if (!rst_sync_r) begin
         div_kick_r <= 1'b0;
      end else begin
         div_kick_r <= state_r[ST_WAIT_DONE_BIT] && bus.gcd_ready;
      end
   end

   // Operand, GCD and result registers.
   always_ff @(posedge clk or negedge rst_sync_r) begin
      if (!rst_sync_r) begin
         a_r       <= {W{1'b0}};
         b_r       <= {W{1'b0}};
         gcd_val_r <= {W{1'b0}};
         num_r     <= {W{1'b0}};
         den_r     <= {W{1'b0}};
         err_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  a_r       <= bus.a_in;
                  b_r       <= bus.b_in;
                  gcd_val_r <= {W{1'b0}};
                  num_r     <= {W{1'b0}};
                  den_r     <= {W{1'b0}};
                  err_r     <= both_zero_s;
               end else begin
                  err_r     <= err_r;
               end
            end
            ST_WAIT_DONE: begin
               if (bus.gcd_ready) begin
                  gcd_val_r <= bus.gcd_r;
               end else begin
                  gcd_val_r <= gcd_val_r;
               end
            end
            ST_DIV_A: begin
               if (div_done_s) begin
                  num_r <= div_quo_s;
                  err_r <= err_r | (div_rem_s != {W{1'b0}});
               end else begin
                  num_r <= num_r;
               end
            end
            ST_DIV_B: begin
               if (div_done_s) begin
                  den_r <= div_quo_s;
                  err_r <= err_r | (div_rem_s != {W{1'b0}});
               end else begin
                  den_r <= den_r;
               end
            end
            default: begin
               err_r <= err_r;
            end
         endcase
      end
   end

   fraction_reducer_serial_divider #(
      .W (W)
   ) u_divider (
      .clk       (clk),
      .reset     (rst_sync_r),
      .start     (div_start_s),
      .dividend  (div_dividend_s),
      .divisor   (gcd_val_r),
      .done      (div_done_s),
      .quotient  (div_quo_s),
      .remainder (div_rem_s)
   );

   // Handshake flags come straight from one-hot state flops.
   assign bus.in_ready  = state_r[ST_IDLE_BIT];
   assign bus.gcd_start = state_r[ST_LAUNCH_BIT];
   assign bus.out_valid = state_r[ST_OUT_BIT];
   assign bus.gcd_a     = a_r;
   assign bus.gcd_b     = b_r;
   assign bus.num_out   = num_r;
   assign bus.den_out   = den_r;
   assign bus.gcd_out   = gcd_val_r;
   assign bus.err       = err_r;

endmodule

// File: tb/tb_fraction_reducer.sv
// -----------------------------------------------------------------------------
// tb_fraction_reducer
// Directed-vector bench for fraction_reducer with a behavioural GCD engine
// whose busy time is G cycles (gcd_ready low for exactly G cycles).
// -----------------------------------------------------------------------------
module tb_fraction_reducer;
   import fraction_reducer_pkg::*;

   localparam int unsigned W   = FR_W;
   localparam int          G   = 5;
   localparam int          LAT = 3 + G + 2 * W;
   localparam int          TMO = 200;

   logic         clk;
   logic         reset;
   int           checks    = 0;
   int           errors    = 0;
   int           cyc       = 0;
   int           start_cnt = 0;
   int           eng_cnt;
   logic [W-1:0] eng_a;
   logic [W-1:0] eng_b;

   fraction_reducer_if #(.W(W)) fr_bus ();

   fraction_reducer #(.W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (fr_bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Free-running cycle counter and gcd_start high-cycle counter.
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (fr_bus.gcd_start) start_cnt <= start_cnt + 1;

   function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] x, y, t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Behavioural GCD engine: takes a launch while idle, stays busy G cycles.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         fr_bus.gcd_ready <= 1'b1;
         fr_bus.gcd_r     <= '0;
         eng_cnt          <= 0;
         eng_a            <= '0;
         eng_b            <= '0;
      end else if (eng_cnt != 0) begin
         eng_cnt <= eng_cnt - 1;
         if (eng_cnt == 1) begin
            fr_bus.gcd_ready <= 1'b1;
            fr_bus.gcd_r     <= ref_gcd(eng_a, eng_b);
         end
      end else if (fr_bus.gcd_start && fr_bus.gcd_ready) begin
         eng_a            <= fr_bus.gcd_a;
         eng_b            <= fr_bus.gcd_b;
         eng_cnt          <= G;
         fr_bus.gcd_ready <= 1'b0;
      end
   end

   // Present a pair for one cycle (called at a negedge while in_ready=1).
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output int t0);
      fr_bus.in_valid = 1'b1;
      fr_bus.a_in     = a;
      fr_bus.b_in     = b;
      @(negedge clk);
      t0 = cyc;
      fr_bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(output logic found);
      found = 1'b0;
      for (int i = 0; i < TMO && !found; i++) begin
         if (fr_bus.out_valid) found = 1'b1;
         else @(negedge clk);
      end
   endtask

   task automatic transfer();
      fr_bus.out_ready = 1'b1;
      @(negedge clk);
      fr_bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (fr_bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", fr_bus.in_ready); end
      checks++; if (fr_bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", fr_bus.out_valid); end
      checks++; if (fr_bus.gcd_start !== 1'b0) begin errors++; $display("FAIL reset_gcd_start: got %b expected 0", fr_bus.gcd_start); end
      checks++; if ({fr_bus.num_out, fr_bus.den_out, fr_bus.gcd_out, fr_bus.err, fr_bus.gcd_a, fr_bus.gcd_b} !== '0) begin
         errors++; $display("FAIL reset_data: got num=%0d den=%0d gcd=%0d err=%b expected all 0", fr_bus.num_out, fr_bus.den_out, fr_bus.gcd_out, fr_bus.err);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int   t0, s0, lat;
      logic found;
      s0 = start_cnt;
      send(7'd84, 7'd36, t0);
      checks++; if (fr_bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy_in_ready: got %b expected 0", fr_bus.in_ready); end
      checks++; if (fr_bus.gcd_start !== 1'b1) begin errors++; $display("FAIL basic_gcd_start: got %b expected 1", fr_bus.gcd_start); end
      wait_valid(found);
      lat = cyc - t0;
      checks++; if (!found) begin errors++; $display("FAIL basic_timeout: out_valid got 0 expected 1"); end
      checks++; if (lat !== LAT) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT); end
      checks++; if (fr_bus.gcd_out !== 7'd12) begin errors++; $display("FAIL basic_gcd: got %0d expected 12", fr_bus.gcd_out); end
      checks++; if (fr_bus.num_out !== 7'd7) begin errors++; $display("FAIL basic_num: got %0d expected 7", fr_bus.num_out); end
      checks++; if (fr_bus.den_out !== 7'd3) begin errors++; $display("FAIL basic_den: got %0d expected 3", fr_bus.den_out); end
      checks++; if (fr_bus.err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", fr_bus.err); end
      checks++; if ({fr_bus.gcd_a, fr_bus.gcd_b} !== {7'd84, 7'd36}) begin errors++; $display("FAIL basic_gcd_ops: got %0d/%0d expected 84/36", fr_bus.gcd_a, fr_bus.gcd_b); end
      checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL basic_start_cycles: got %0d expected 1", start_cnt - s0); end
      transfer();
      checks++; if (fr_bus.out_valid !== 1'b0 || fr_bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_release: got valid=%b ready=%b expected 0/1", fr_bus.out_valid, fr_bus.in_ready); end
   endtask

   task automatic test_zero_operands();
      int           t0, s0;
      logic         found;
      logic [W-1:0] tv_a   [0:2];
      logic [W-1:0] tv_b   [0:2];
      logic [W-1:0] tv_num [0:2];
      logic [W-1:0] tv_den [0:2];
      logic [W-1:0] tv_gcd [0:2];
      tv_a[0] = 7'd0;   tv_b[0] = 7'd45; tv_num[0] = 7'd0;   tv_den[0] = 7'd1; tv_gcd[0] = 7'd45;
      tv_a[1] = 7'd127; tv_b[1] = 7'd0;  tv_num[1] = 7'd1;   tv_den[1] = 7'd0; tv_gcd[1] = 7'd127;
      tv_a[2] = 7'd127; tv_b[2] = 7'd1;  tv_num[2] = 7'd127; tv_den[2] = 7'd1; tv_gcd[2] = 7'd1;

      s0 = start_cnt;
      send(7'd0, 7'd0, t0);
      checks++; if (fr_bus.out_valid !== 1'b1) begin errors++; $display("FAIL zz_out_valid: got %b expected 1", fr_bus.out_valid); end
      checks++; if ({fr_bus.num_out, fr_bus.den_out, fr_bus.gcd_out} !== '0) begin errors++; $display("FAIL zz_data: got %0d/%0d gcd=%0d expected 0/0 gcd=0", fr_bus.num_out, fr_bus.den_out, fr_bus.gcd_out); end
      checks++; if (fr_bus.err !== 1'b1) begin errors++; $display("FAIL zz_err: got %b expected 1", fr_bus.err); end
      transfer();
      checks++; if (start_cnt !== s0) begin errors++; $display("FAIL zz_no_launch: got %0d start cycles expected 0", start_cnt - s0); end

      for (int i = 0; i < 3; i++) begin
         send(tv_a[i], tv_b[i], t0);
         wait_valid(found);
         checks++; if (!found) begin errors++; $display("FAIL edge%0d_timeout: out_valid got 0 expected 1", i); end
         checks++; if ({fr_bus.num_out, fr_bus.den_out, fr_bus.gcd_out, fr_bus.err} !== {tv_num[i], tv_den[i], tv_gcd[i], 1'b0}) begin
            errors++; $display("FAIL edge%0d_result: got %0d/%0d gcd=%0d err=%b expected %0d/%0d gcd=%0d err=0",
                               i, fr_bus.num_out, fr_bus.den_out, fr_bus.gcd_out, fr_bus.err, tv_num[i], tv_den[i], tv_gcd[i]);
         end
         transfer();
      end
   endtask

   task automatic test_backpressure();
      int   t0;
      logic found;
      send(7'd96, 7'd64, t0);
      wait_valid(found);
      checks++; if (!found) begin errors++; $display("FAIL bp_timeout: out_valid got 0 expected 1"); end
      for (int i = 0; i < 5; i++) begin
         checks++; if ({fr_bus.out_valid, fr_bus.in_ready, fr_bus.num_out, fr_bus.den_out, fr_bus.gcd_out} !== {1'b1, 1'b0, 7'd3, 7'd2, 7'd32}) begin
            errors++; $display("FAIL bp_hold%0d: got valid=%b ready=%b %0d/%0d gcd=%0d expected 1/0 3/2 gcd=32",
                               i, fr_bus.out_valid, fr_bus.in_ready, fr_bus.num_out, fr_bus.den_out, fr_bus.gcd_out);
         end
         @(negedge clk);
      end
      checks++; if ({fr_bus.out_valid, fr_bus.num_out, fr_bus.den_out} !== {1'b1, 7'd3, 7'd2}) begin errors++; $display("FAIL bp_sixth: got valid=%b %0d/%0d expected 1 3/2", fr_bus.out_valid, fr_bus.num_out, fr_bus.den_out); end
      transfer();
      checks++; if (fr_bus.out_valid !== 1'b0 || fr_bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", fr_bus.out_valid, fr_bus.in_ready); end
   endtask

   task automatic test_back_to_back();
      int   t0;
      logic found;
      send(7'd84, 7'd36, t0);
      repeat (8) @(negedge clk);
      // Now inside the first division; this pair must be ignored.
      checks++; if (fr_bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy_ready: got %b expected 0", fr_bus.in_ready); end
      fr_bus.in_valid = 1'b1;
      fr_bus.a_in     = 7'd5;
      fr_bus.b_in     = 7'd10;
      @(negedge clk);
      fr_bus.in_valid = 1'b0;
      wait_valid(found);
      checks++; if (!found) begin errors++; $display("FAIL b2b_timeout1: out_valid got 0 expected 1"); end
      checks++; if ({fr_bus.num_out, fr_bus.den_out, fr_bus.gcd_out} !== {7'd7, 7'd3, 7'd12}) begin errors++; $display("FAIL b2b_ignore: got %0d/%0d gcd=%0d expected 7/3 gcd=12", fr_bus.num_out, fr_bus.den_out, fr_bus.gcd_out); end
      transfer();
      send(7'd5, 7'd10, t0);
      wait_valid(found);
      checks++; if (!found) begin errors++; $display("FAIL b2b_timeout2: out_valid got 0 expected 1"); end
      checks++; if ({fr_bus.num_out, fr_bus.den_out, fr_bus.gcd_out, fr_bus.err} !== {7'd1, 7'd2, 7'd5, 1'b0}) begin errors++; $display("FAIL b2b_second: got %0d/%0d gcd=%0d err=%b expected 1/2 gcd=5 err=0", fr_bus.num_out, fr_bus.den_out, fr_bus.gcd_out, fr_bus.err); end
      transfer();
   endtask

   task automatic test_reset_mid();
      int   t0, lat;
      logic found;
      send(7'd84, 7'd36, t0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if (fr_bus.out_valid !== 1'b0 || fr_bus.in_ready !== 1'b1 || fr_bus.gcd_start !== 1'b0) begin
         errors++; $display("FAIL midrst_flags: got valid=%b ready=%b start=%b expected 0/1/0", fr_bus.out_valid, fr_bus.in_ready, fr_bus.gcd_start);
      end
      checks++; if ({fr_bus.num_out, fr_bus.den_out, fr_bus.gcd_out, fr_bus.err, fr_bus.gcd_a} !== '0) begin errors++; $display("FAIL midrst_data: got gcd_a=%0d expected all 0", fr_bus.gcd_a); end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      send(7'd20, 7'd8, t0);
      wait_valid(found);
      lat = cyc - t0;
      checks++; if (!found) begin errors++; $display("FAIL midrst_timeout: out_valid got 0 expected 1"); end
      checks++; if (lat !== LAT) begin errors++; $display("FAIL midrst_latency: got %0d expected %0d", lat, LAT); end
      checks++; if ({fr_bus.num_out, fr_bus.den_out, fr_bus.gcd_out, fr_bus.err} !== {7'd5, 7'd2, 7'd4, 1'b0}) begin errors++; $display("FAIL midrst_result: got %0d/%0d gcd=%0d err=%b expected 5/2 gcd=4 err=0", fr_bus.num_out, fr_bus.den_out, fr_bus.gcd_out, fr_bus.err); end
      transfer();
   endtask

   initial begin
      reset            = 1'b0;
      fr_bus.in_valid  = 1'b0;
      fr_bus.a_in      = '0;
      fr_bus.b_in      = '0;
      fr_bus.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_zero_operands();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
